// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, funct3 encodings and legality helper for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } lsu_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Exactly one of load/store, a known size code for that direction, natural alignment.
    function automatic logic access_legal(logic rd, logic wr, logic [2:0] f3, logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = !a[0];
            F3_LW:   ok = (a == 2'b00);
            F3_LBU:  ok = rd;
            F3_LHU:  ok = rd && !a[0];
            default: ok = 1'b0;
        endcase
        return ok && (rd != wr);
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed byte/halfword of a read word
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection by address offset, then sign or zero extension by access type.
    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'b0, byte_sel};
            F3_LHU:  data_o = {16'b0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store bus master with timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           err_q;
    logic [31:0]    addr_q;
    logic [2:0]     funct3_q;
    logic           rd_q;
    logic           we_q;
    logic [3:0]     be_q;
    logic [31:0]    bwdata_q;
    logic [31:0]    rdata_q;

    logic [3:0]     be_d;
    logic [31:0]    bwdata_d;
    logic           legal;
    logic [31:0]    load_val;

    assign legal = access_legal(mem_read, mem_write, funct3, addr[1:0]);

    // Store lane enables and replicated data, computed from the live operands at capture.
    always_comb begin
        be_d     = 4'b1111;
        bwdata_d = wdata;
        if (mem_write && !mem_read) begin
            case (funct3)
                F3_SB: begin
                    be_d     = 4'b0001 << addr[1:0];
                    bwdata_d = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be_d     = 4'b0011 << {addr[1], 1'b0};
                    bwdata_d = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_align u_load_align (
        .word_i   (bus_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_val)
    );

    // Access sequencing: capture on start, hold the request until ack or timeout, one-cycle finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            funct3_q <= '0;
            rd_q     <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            bwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
                        if (legal) begin
                            addr_q   <= addr;
                            funct3_q <= funct3;
                            rd_q     <= mem_read;
                            we_q     <= mem_write;
                            be_q     <= be_d;
                            bwdata_q <= bwdata_d;
                            state_q  <= S_REQ;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        err_q   <= 1'b0;
                        state_q <= S_FIN;
                        if (rd_q) begin
                            rdata_q <= load_val;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FIN);
    assign err       = err_q;
    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = bwdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int unsigned len;
    } bus_t;

    done_t       dq[$];
    bus_t        bq[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int unsigned ack_cycle = 0;
    logic [31:0] ack_word = '0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference rules written as plain arithmetic on access size in bytes.
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic bit m_legal(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = int'(f3);
        if (rd == wr) return 0;
        if (rd && !(v == 0 || v == 1 || v == 2 || v == 4 || v == 5)) return 0;
        if (wr && v > 2) return 0;
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int unsigned sz;
        longint v;
        sz = m_size(f3);
        if (sz == 4) return w;
        v = (longint'(w) >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (f3 < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = m_size(f3);
        if (!wr || sz == 4) return 4'hF;
        return 4'((sz == 1 ? 1 : 3) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input bit wr, input logic [2:0] f3, input logic [31:0] wd);
        int unsigned sz;
        sz = m_size(f3);
        if (!wr || sz == 4) return wd;
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        return (wd & 32'hFFFF) * 32'h0001_0001;
    endfunction

    // Memory responder: one-cycle ack at the cycle chosen by the stimulus, junk data otherwise.
    initial begin
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_ack   = (cyc == ack_cycle);
            bus_rdata = bus_ack ? ack_word : $urandom;
        end
    end

    // Completion monitor.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (dq.size() == 0) begin
                    note_fail("done_unexpected");
                end else begin
                    e = dq.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("err", {31'b0, err}, {31'b0, e.err});
                    check("rdata", rdata, e.rdata);
                end
            end
        end
    end

    // Bus monitor: operands stable for every request cycle, request length as expected.
    initial begin
        bit          prev_req;
        int unsigned req_len;
        bus_t        b;
        prev_req = 0;
        req_len  = 0;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (bq.size() == 0) begin
                    note_fail("bus_req_unexpected");
                end else begin
                    b = bq[0];
                    check("bus_addr", bus_addr, b.addr);
                    check("bus_we", {31'b0, bus_we}, {31'b0, b.we});
                    check("bus_be", {28'b0, bus_be}, {28'b0, b.be});
                    check("bus_wdata", bus_wdata, b.wdata);
                end
                req_len++;
            end else if (prev_req) begin
                if (bq.size() != 0) begin
                    b = bq.pop_front();
                    check("req_len", req_len, b.len);
                end
                req_len = 0;
            end
            prev_req = bus_req;
        end
    end

    task automatic scramble_inputs();
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        funct3    = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
    endtask

    task automatic wait_past_ack();
        int k;
        k = 0;
        while (cyc <= ack_cycle && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int d, input bit restart);
        int unsigned c0;
        int unsigned fin;
        int unsigned len;
        bit          ok;
        bit          succ;
        int          k;
        @(posedge clk);
        #1;
        c0 = cyc;
        ok = m_legal(rd, wr, f3, a);
        succ = ok && (d < TO);
        len = (d < TO) ? d + 1 : TO;
        if (ok) begin
            bq.push_back('{addr: a & 32'hFFFF_FFFC, we: wr, be: m_be(wr, f3, a),
                           wdata: m_wdata(wr, f3, wd), len: len});
            fin = c0 + 1 + len;
            if (succ && rd) m_rdata = m_load(f3, a, word);
        end else begin
            fin = c0 + 1;
        end
        dq.push_back('{cyc: fin, err: !succ, rdata: m_rdata});
        ack_cycle = c0 + 1 + d;
        ack_word  = word;
        start     = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        if (restart) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) note_fail("busy_stuck");
        check("idle_cycle", cyc, fin + 1);
        wait_past_ack();
    endtask

    task automatic do_rst_abort(input logic [31:0] a, input logic [31:0] word);
        int unsigned c0;
        @(posedge clk);
        #1;
        c0 = cyc;
        bq.push_back('{addr: a & 32'hFFFF_FFFC, we: 1'b0, be: 4'hF, wdata: 32'h0, len: 2});
        ack_cycle = c0 + 4;
        ack_word  = word;
        start     = 1'b1;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        funct3    = 3'b010;
        addr      = a;
        wdata     = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_rdata = '0;
        check("rst_abort_bus_req", {31'b0, bus_req}, 32'd0);
        check("rst_abort_busy", {31'b0, busy}, 32'd0);
        wait_past_ack();
        @(posedge clk);
        #1;
        check("ack_after_rst_ignored_busy", {31'b0, busy}, 32'd0);
        check("rdata_after_rst", rdata, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        int          kind;
        int          tmp;
        rst       = 1'b1;
        start     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = '0;
        addr      = '0;
        wdata     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_bus_req", {31'b0, bus_req}, 32'd0);
        check("reset_bus_we", {31'b0, bus_we}, 32'd0);
        check("reset_bus_be", {28'b0, bus_be}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b0;

        do_txn(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 3, 0);
        do_txn(1, 0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 1, 0);
        do_txn(1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'hDEAD_BEEF, 0, 0);
        do_txn(0, 1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0, 2, 0);
        do_txn(0, 1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'h0, 5, 0);
        do_txn(1, 1, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 1, 0);
        do_txn(1, 0, 3'b011, 32'h0000_0400, 32'h0, 32'h0, 2, 0);
        do_txn(0, 0, 3'b000, 32'h0000_0400, 32'h0, 32'h0, 0, 0);
        do_txn(1, 0, 3'b001, 32'h0000_0506, 32'h0, 32'h7FFF_8000, 2, 1);
        do_txn(0, 1, 3'b001, 32'h0000_0602, 32'hCAFE_1357, 32'h0, 0, 0);
        do_rst_abort(32'h0000_0700, 32'h1111_2222);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                rd = 1; wr = 0;
            end else if (kind < 9) begin
                rd = 0; wr = 1;
            end else begin
                rd = 1'($urandom); wr = rd;
            end
            if ($urandom_range(0, 4) == 0) begin
                f3 = 3'($urandom);
            end else if (rd) begin
                tmp = $urandom_range(0, 4);
                f3 = 3'(tmp + ((tmp >= 3) ? 1 : 0));
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
            do_txn(rd, wr, f3, $urandom, $urandom, $urandom, $urandom_range(0, 5),
                   $urandom_range(0, 3) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("done_queue_drained", dq.size(), 32'd0);
        check("bus_queue_drained", bq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
